vme_data_transfer: RTL and testbench
====================================

// Module: vme_data_transfer
// PURPOSE
// - Converts one MC68030 bus cycle into one VMEbus data-transfer cycle once the VME bus is owned.
// - Drives VME AS*/DS1*/DS0*/LWORD*/WRITE*/AM[5:0] and returns 68030 DSACK[1:0].
// - Steers the board's address/data transceiver enables and directions.
// - Sits between the CPU bus decoder/arbiter (request_vme, bus_acquired) and the VME transceivers.
// PARAMETERS
// - none (AM codes and SIZ encodings are constants in the package)
// PORTS (all *_oe, strobes, acks and requests active-low)
// - clock            in   1  system clock; everything on its rising edge
// - reset            in   1  synchronous, active-high
// - request_vme      in   1  CPU cycle decodes to VME space
// - bus_acquired     in   1  arbiter reports this board owns the VME bus
// - cpu_as, cpu_ds   in   1  68030 address / data strobe
// - cpu_write        in   1  68030 R/W (1 = read)
// - cpu_siz          in   2  00 long, 01 byte, 10 word, 11 three-byte
// - cpu_address      in   2  A1:A0
// - cpu_fc           in   3  function code
// - cpu_dsack        out  2  {DSACK1,DSACK0}
// - vme_as           out  1  VME AS*
// - vme_ds           out  2  {DS1*,DS0*}; DS1 = even byte D15-8, DS0 = odd byte D7-0
// - vme_lword        out  1  VME LWORD*
// - vme_write        out  1  VME WRITE* (0 = write)
// - vme_address_mod  out  6  VME AM code
// - vme_dtack, vme_berr  in  1  VME DTACK*, BERR*
// - addr_low_oe      out  1  CPU address -> VME low address lines (A23-A1)
// - a40_cross_oe     out  1  A40 data-lane-to-address crossing; always 1 (A40 not supported)
// - data_low_oe / data_low_dir    out 1/1  CPU D15-0 <-> VME D15-0
// - d16_cross_oe / d16_cross_dir  out 1/1  CPU D31-16 <-> VME D15-0
// - md32_cross_oe / md32_cross_dir out 1/1 CPU D31-16 <-> VME address lines (MD32)
// BEHAVIOUR
// - Reset: state IDLE; all strobes, dsack, *_oe = 1; vme_write = 1; *_dir = 0; AM = 6'h00.
// - *_dir: 1 = CPU->VME (cpu_write=0), 0 = VME->CPU; valid whenever the matching oe is 0.
// - Cycle class latched on IDLE->ADDRESS: LONG if siz=00 and addr=00; else ODD if addr[0]=1;
//   else EVEN if siz=01; else WORD. Misaligned/three-byte accesses rely on 68030 dynamic sizing.
// - AM latched from fc: fc[2]=1 -> 0x0D data / 0x0E program (fc[1]=1); else 0x09 / 0x0A.
// - IDLE -> ADDRESS when cpu_as, cpu_ds, request_vme, bus_acquired all 0 and dtack, berr both 1.
// - ADDRESS (1 clk): addr_low_oe=0; lword=0 if LONG; write, AM driven; vme_as still 1. -> DATA.
// - DATA: vme_as=0; ds: LONG/WORD 00, EVEN 01, ODD 10; LONG: addr_low_oe=1, md32_cross_oe=0,
//   data_low_oe=0; WORD/EVEN/ODD: addr_low_oe=0, d16_cross_oe=0. data_low_oe and md32_cross_oe
//   are 0 (d16_cross_oe 1) within 2 rising edges of strobes asserting. Other oes stay 1.
// - DATA: dtack=0 -> ACK; berr=0 -> ERROR (berr wins if both).
// - ACK: VME signals held; cpu_dsack = 00 (LONG) or 01 (16-bit port: DSACK1 only) until cpu_as=1
//   -> RELEASE.
// - ERROR: VME signals held; dsack stays 11 (CPU bus watchdog signals the error) until cpu_as=1.
// - RELEASE: all strobes, dsack, oes back to reset values; wait dtack=1 and berr=1 -> IDLE.
// - cpu_as or bus_acquired going 1 in ADDRESS/DATA aborts -> RELEASE; no dsack issued.
// - reset mid-cycle: next edge returns to IDLE with reset outputs; cycle is lost.
// STRUCTURE
// - Package vme_pkg: SIZ encodings, cycle-class enum, state enum, AM constants.
// - Single module; no sub-module (state register + latched class/AM + output decode).
// TESTING
// - Long read: siz=00, addr=00, all requests 0 -> after 2 edges data_low_oe=0, md32_cross_oe=0,
//   d16_cross_oe=1, vme_ds=00, lword=0, AM=0x09; dtack=0 -> dsack=00; cpu_as=1 -> dsack=11.
// - Word read: siz=10 -> ds=00, lword=1, d16_cross_oe=0, addr_low_oe=0; dtack -> dsack=01.
// - Byte even siz=01 addr=00 -> ds=01; byte odd addr=01 -> ds=10; both end with dsack=01.
// - Write: cpu_write=0 -> vme_write=0, active *_dir=1; fc=101 -> AM=0x0D.
// - berr=0 in DATA -> dsack stays 11; cpu_as=1 -> RELEASE; no new cycle until dtack/berr=1.
// - reset=1 mid DATA -> next edge all outputs at reset values.

Source files
------------

// File: rtl/vme_data_transfer_pkg.sv
// Shared types and constants for the MC68030-to-VMEbus data-transfer block.
// SIZ encodings, cycle classes, FSM states, AM codes and the registered output bundle.
package vme_data_transfer_pkg;

  localparam logic [1:0] SIZ_LONG  = 2'b00;
  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_THREE = 2'b11;

  localparam logic [5:0] AM_NONE     = 6'h00;
  localparam logic [5:0] AM_STD_DATA = 6'h09;
  localparam logic [5:0] AM_STD_PROG = 6'h0A;
  localparam logic [5:0] AM_SUP_DATA = 6'h0D;
  localparam logic [5:0] AM_SUP_PROG = 6'h0E;

  typedef enum logic [1:0] {
    CLS_LONG,
    CLS_WORD,
    CLS_EVEN,
    CLS_ODD
  } cycle_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDRESS,
    ST_DATA,
    ST_ACK,
    ST_ERROR,
    ST_RELEASE
  } state_e;

  typedef struct packed {
    logic [1:0] cpu_dsack;
    logic       vme_as;
    logic [1:0] vme_ds;
    logic       vme_lword;
    logic       vme_write;
    logic [5:0] vme_address_mod;
    logic       addr_low_oe;
    logic       data_low_oe;
    logic       data_low_dir;
    logic       d16_cross_oe;
    logic       d16_cross_dir;
    logic       md32_cross_oe;
    logic       md32_cross_dir;
  } bus_out_t;

  localparam bus_out_t OUT_RESET = '{
    cpu_dsack:       2'b11,
    vme_as:          1'b1,
    vme_ds:          2'b11,
    vme_lword:       1'b1,
    vme_write:       1'b1,
    vme_address_mod: AM_NONE,
    addr_low_oe:     1'b1,
    data_low_oe:     1'b1,
    data_low_dir:    1'b0,
    d16_cross_oe:    1'b1,
    d16_cross_dir:   1'b0,
    md32_cross_oe:   1'b1,
    md32_cross_dir:  1'b0
  };

  // Anything not a full aligned long goes out as a 16-bit cycle; the 68030
  // sizes the remainder dynamically from the DSACK1-only response.
  function automatic cycle_class_e classify(input logic [1:0] siz, input logic [1:0] addr);
    if (addr[0]) return CLS_ODD;
    case (siz)
      SIZ_LONG:            return addr[1] ? CLS_WORD : CLS_LONG;
      SIZ_BYTE:            return CLS_EVEN;
      SIZ_WORD, SIZ_THREE: return CLS_WORD;
    endcase
  endfunction

  function automatic logic [5:0] am_code(input logic [2:0] fc);
    if (fc[2]) return fc[1] ? AM_SUP_PROG : AM_SUP_DATA;
    return fc[1] ? AM_STD_PROG : AM_STD_DATA;
  endfunction

endpackage

// File: rtl/vme_data_transfer_if.sv
// CPU-side and VME-side signal bundle for vme_data_transfer.
// master is the view of the transfer block; slave is the view of its surroundings.
interface vme_data_transfer_if;

  logic       request_vme;
  logic       bus_acquired;
  logic       cpu_as;
  logic       cpu_ds;
  logic       cpu_write;
  logic [1:0] cpu_siz;
  logic [1:0] cpu_address;
  logic [2:0] cpu_fc;
  logic [1:0] cpu_dsack;
  logic       vme_as;
  logic [1:0] vme_ds;
  logic       vme_lword;
  logic       vme_write;
  logic [5:0] vme_address_mod;
  logic       vme_dtack;
  logic       vme_berr;
  logic       addr_low_oe;
  logic       a40_cross_oe;
  logic       data_low_oe;
  logic       data_low_dir;
  logic       d16_cross_oe;
  logic       d16_cross_dir;
  logic       md32_cross_oe;
  logic       md32_cross_dir;

  modport master (
    input  request_vme, bus_acquired, cpu_as, cpu_ds, cpu_write, cpu_siz, cpu_address,
           cpu_fc, vme_dtack, vme_berr,
    output cpu_dsack, vme_as, vme_ds, vme_lword, vme_write, vme_address_mod,
           addr_low_oe, a40_cross_oe, data_low_oe, data_low_dir, d16_cross_oe,
           d16_cross_dir, md32_cross_oe, md32_cross_dir
  );

  modport slave (
    output request_vme, bus_acquired, cpu_as, cpu_ds, cpu_write, cpu_siz, cpu_address,
           cpu_fc, vme_dtack, vme_berr,
    input  cpu_dsack, vme_as, vme_ds, vme_lword, vme_write, vme_address_mod,
           addr_low_oe, a40_cross_oe, data_low_oe, data_low_dir, d16_cross_oe,
           d16_cross_dir, md32_cross_oe, md32_cross_dir
  );

endinterface

// File: rtl/vme_data_transfer.sv
// Runs one VMEbus data-transfer cycle per MC68030 bus cycle once this board owns VME.
// All outputs come straight from a register loaded with the next state's values.
module vme_data_transfer
  import vme_data_transfer_pkg::*;
(
  input logic              clock,
  input logic              reset,
  vme_data_transfer_if.master bus
);

  state_e       state;
  cycle_class_e cls;
  bus_out_t     outs;
  logic         start;
  logic         abort;

  assign start = !bus.cpu_as && !bus.cpu_ds && !bus.request_vme && !bus.bus_acquired &&
                 bus.vme_dtack && bus.vme_berr;
  assign abort = bus.cpu_as || bus.bus_acquired;

  function automatic bus_out_t address_phase(input cycle_class_e c, input logic [2:0] fc,
                                             input logic wr);
    bus_out_t o;
    o                 = OUT_RESET;
    o.addr_low_oe     = 1'b0;
    o.vme_lword       = (c != CLS_LONG);
    o.vme_write       = wr;
    o.vme_address_mod = am_code(fc);
    o.data_low_dir    = !wr;
    o.d16_cross_dir   = !wr;
    o.md32_cross_dir  = !wr;
    return o;
  endfunction

  // Long transfers carry the upper CPU half on the VME address lines (MD32),
  // so the address drivers must be off while data is on the bus.
  function automatic bus_out_t data_phase(input cycle_class_e c, input bus_out_t held);
    bus_out_t o;
    o        = held;
    o.vme_as = 1'b0;
    case (c)
      CLS_EVEN: o.vme_ds = 2'b01;
      CLS_ODD:  o.vme_ds = 2'b10;
      default:  o.vme_ds = 2'b00;
    endcase
    if (c == CLS_LONG) begin
      o.addr_low_oe   = 1'b1;
      o.md32_cross_oe = 1'b0;
      o.data_low_oe   = 1'b0;
    end else begin
      o.addr_low_oe  = 1'b0;
      o.d16_cross_oe = 1'b0;
    end
    return o;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cls   <= CLS_WORD;
      outs  <= OUT_RESET;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cls   <= classify(bus.cpu_siz, bus.cpu_address);
            outs  <= address_phase(classify(bus.cpu_siz, bus.cpu_address), bus.cpu_fc,
                                   bus.cpu_write);
            state <= ST_ADDRESS;
          end
        end
        ST_ADDRESS: begin
          if (abort) begin
            outs  <= OUT_RESET;
            state <= ST_RELEASE;
          end else begin
            outs  <= data_phase(cls, outs);
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (abort) begin
            outs  <= OUT_RESET;
            state <= ST_RELEASE;
          end else if (!bus.vme_berr) begin
            state <= ST_ERROR;
          end else if (!bus.vme_dtack) begin
            outs.cpu_dsack <= (cls == CLS_LONG) ? 2'b00 : 2'b01;
            state          <= ST_ACK;
          end
        end
        ST_ACK, ST_ERROR: begin
          if (bus.cpu_as) begin
            outs  <= OUT_RESET;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (bus.vme_dtack && bus.vme_berr) state <= ST_IDLE;
        end
        default: begin
          outs  <= OUT_RESET;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_dsack       = outs.cpu_dsack;
  assign bus.vme_as          = outs.vme_as;
  assign bus.vme_ds          = outs.vme_ds;
  assign bus.vme_lword       = outs.vme_lword;
  assign bus.vme_write       = outs.vme_write;
  assign bus.vme_address_mod = outs.vme_address_mod;
  assign bus.addr_low_oe     = outs.addr_low_oe;
  assign bus.a40_cross_oe    = 1'b1;
  assign bus.data_low_oe     = outs.data_low_oe;
  assign bus.data_low_dir    = outs.data_low_dir;
  assign bus.d16_cross_oe    = outs.d16_cross_oe;
  assign bus.d16_cross_dir   = outs.d16_cross_dir;
  assign bus.md32_cross_oe   = outs.md32_cross_oe;
  assign bus.md32_cross_dir  = outs.md32_cross_dir;

endmodule

// File: tb/tb_vme_data_transfer.sv
// Randomized bench for vme_data_transfer: each CPU cycle is compared phase by phase
// against expectations derived from the cycle parameters alone.
module tb_vme_data_transfer;

  localparam int PH_IDLE = 0;
  localparam int PH_ADDR = 1;
  localparam int PH_DATA = 2;
  localparam int PH_ACK  = 3;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  vme_data_transfer_if bus ();

  vme_data_transfer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Direction bits only matter while their enable is active, so they are masked otherwise.
  function automatic logic [20:0] observed();
    return {bus.cpu_dsack, bus.vme_as, bus.vme_ds, bus.vme_lword, bus.vme_write,
            bus.vme_address_mod, bus.addr_low_oe,
            bus.data_low_oe, bus.data_low_oe ? 1'b0 : bus.data_low_dir,
            bus.d16_cross_oe, bus.d16_cross_oe ? 1'b0 : bus.d16_cross_dir,
            bus.md32_cross_oe, bus.md32_cross_oe ? 1'b0 : bus.md32_cross_dir,
            bus.a40_cross_oe};
  endfunction

  function automatic logic [20:0] expect_vec(input int phase, input logic [1:0] siz,
                                             input logic [1:0] addr, input logic [2:0] fc,
                                             input logic wr);
    logic       is_long, is_odd, is_even, dir;
    logic [1:0] dsack, ds;
    logic [5:0] am;
    logic       as_n, lw, we, alo, dlo, d16, md32;
    is_long = (siz == 2'b00) && (addr == 2'b00);
    is_odd  = addr[0];
    is_even = !is_long && !is_odd && (siz == 2'b01);
    dir     = !wr;
    dsack = 2'b11; as_n = 1'b1; ds = 2'b11; lw = 1'b1; we = 1'b1; am = 6'h00;
    alo = 1'b1; dlo = 1'b1; d16 = 1'b1; md32 = 1'b1;
    if (phase >= PH_ADDR) begin
      lw  = !is_long;
      we  = wr;
      am  = 6'h09 + (fc[2] ? 6'd4 : 6'd0) + (fc[1] ? 6'd1 : 6'd0);
      alo = 1'b0;
    end
    if (phase >= PH_DATA) begin
      as_n = 1'b0;
      ds   = is_even ? 2'b01 : (is_odd ? 2'b10 : 2'b00);
      if (is_long) begin
        alo = 1'b1; dlo = 1'b0; md32 = 1'b0;
      end else begin
        d16 = 1'b0;
      end
    end
    if (phase == PH_ACK) dsack = is_long ? 2'b00 : 2'b01;
    return {dsack, as_n, ds, lw, we, am, alo, dlo, dlo ? 1'b0 : dir, d16, d16 ? 1'b0 : dir,
            md32, md32 ? 1'b0 : dir, 1'b1};
  endfunction

  task automatic go_idle();
    bus.cpu_as = 1'b1; bus.cpu_ds = 1'b1; bus.request_vme = 1'b1; bus.bus_acquired = 1'b1;
    tick();
    bus.vme_dtack = 1'b1; bus.vme_berr = 1'b1;
    tick();
    tick();
  endtask

  // outcome: 0 dtack, 1 berr, 2 cpu_as abort in DATA, 3 bus loss in ADDRESS, 4 reset in DATA
  task automatic applyStimulus(input logic [1:0] siz, input logic [1:0] addr,
                               input logic [2:0] fc, input logic wr, input int outcome,
                               input int stall);
    bus.cpu_siz = siz; bus.cpu_address = addr; bus.cpu_fc = fc; bus.cpu_write = wr;
    bus.cpu_as = 1'b0; bus.cpu_ds = 1'b0; bus.request_vme = 1'b0; bus.bus_acquired = 1'b0;
    tick();
    checkOutput("address", observed(), expect_vec(PH_ADDR, siz, addr, fc, wr));
    if (outcome == 3) begin
      bus.bus_acquired = 1'b1;
      tick();
      checkOutput("abort_addr", observed(), expect_vec(PH_IDLE, siz, addr, fc, wr));
    end else begin
      tick();
      checkOutput("data", observed(), expect_vec(PH_DATA, siz, addr, fc, wr));
      case (outcome)
        0: begin
          for (int i = 0; i < stall; i++) begin
            tick();
            checkOutput("data_wait", observed(), expect_vec(PH_DATA, siz, addr, fc, wr));
          end
          bus.vme_dtack = 1'b0;
          tick();
          checkOutput("ack", observed(), expect_vec(PH_ACK, siz, addr, fc, wr));
          for (int i = 0; i < stall; i++) begin
            tick();
            checkOutput("ack_hold", observed(), expect_vec(PH_ACK, siz, addr, fc, wr));
          end
          bus.cpu_as = 1'b1; bus.cpu_ds = 1'b1;
          tick();
          checkOutput("release", observed(), expect_vec(PH_IDLE, siz, addr, fc, wr));
        end
        1: begin
          bus.vme_berr = 1'b0;
          tick();
          checkOutput("error", observed(), expect_vec(PH_DATA, siz, addr, fc, wr));
          for (int i = 0; i < stall; i++) begin
            tick();
            checkOutput("error_hold", observed(), expect_vec(PH_DATA, siz, addr, fc, wr));
          end
          bus.cpu_as = 1'b1; bus.cpu_ds = 1'b1;
          tick();
          checkOutput("release_err", observed(), expect_vec(PH_IDLE, siz, addr, fc, wr));
          bus.cpu_as = 1'b0; bus.cpu_ds = 1'b0;
          tick();
          tick();
          checkOutput("no_restart", observed(), expect_vec(PH_IDLE, siz, addr, fc, wr));
        end
        2: begin
          bus.cpu_as = 1'b1;
          tick();
          checkOutput("abort_data", observed(), expect_vec(PH_IDLE, siz, addr, fc, wr));
        end
        default: begin
          reset = 1'b1;
          tick();
          checkOutput("reset_mid", observed(), expect_vec(PH_IDLE, siz, addr, fc, wr));
          checkOutput("reset_mid_dir", {bus.data_low_dir, bus.d16_cross_dir,
                                        bus.md32_cross_dir}, 32'd0);
          reset = 1'b0;
        end
      endcase
    end
    go_idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    bus.cpu_as = 1'b1; bus.cpu_ds = 1'b1; bus.request_vme = 1'b1; bus.bus_acquired = 1'b1;
    bus.cpu_write = 1'b1; bus.cpu_siz = 2'b00; bus.cpu_address = 2'b00; bus.cpu_fc = 3'b001;
    bus.vme_dtack = 1'b1; bus.vme_berr = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("reset", observed(), expect_vec(PH_IDLE, 2'b00, 2'b00, 3'b001, 1'b1));
    checkOutput("reset_dir", {bus.data_low_dir, bus.d16_cross_dir, bus.md32_cross_dir}, 32'd0);

    applyStimulus(2'b00, 2'b00, 3'b001, 1'b1, 0, 1);
    applyStimulus(2'b10, 2'b00, 3'b010, 1'b1, 0, 0);
    applyStimulus(2'b01, 2'b00, 3'b001, 1'b1, 0, 2);
    applyStimulus(2'b01, 2'b01, 3'b001, 1'b1, 0, 0);
    applyStimulus(2'b00, 2'b00, 3'b101, 1'b0, 0, 1);
    applyStimulus(2'b10, 2'b10, 3'b110, 1'b0, 1, 2);
    applyStimulus(2'b00, 2'b00, 3'b001, 1'b1, 4, 0);
    applyStimulus(2'b11, 2'b10, 3'b101, 1'b0, 2, 0);
    applyStimulus(2'b00, 2'b10, 3'b001, 1'b1, 3, 0);

    for (int n = 0; n < 60; n++) begin
      applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
